// File: rtl/imm_gen_pipe_if.sv
// rtl/imm_gen_pipe_if.sv - instruction-in / immediate-out handshake bundle for imm_gen_pipe
interface imm_gen_pipe_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [2:0]      in_imm_src;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_imm;
  logic [2:0]      out_type;
  logic            out_illegal;

  modport master (
    output in_valid, in_instr, in_imm_src, out_ready,
    input  in_ready, out_valid, out_imm, out_type, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, in_imm_src, out_ready,
    output in_ready, out_valid, out_imm, out_type, out_illegal
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - buffered RISC-V immediate generator; optional counters via IMM_GEN_STATS_EN
module imm_gen_pipe #(
  parameter int XLEN        = 32,
  parameter int FIFO_DEPTH  = 2,
  parameter int AUTO_DECODE = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  imm_gen_pipe_if.slave       bus,
  output logic [15:0]         stat_accepted,
  output logic [15:0]         stat_illegal
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = XLEN + 4;

  logic [31:0]   instr;
  logic [6:0]    opcode;
  logic [2:0]    funct3;
  logic [2:0]    fmt;
  logic [31:0]   imm32;
  logic [XLEN-1:0] imm;
  logic          illegal;

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [EW-1:0] head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          full;
  logic          valid;
  logic          push;
  logic          pop;

  assign instr  = bus.in_instr;
  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];

  always_comb begin
    fmt = 3'b111;
    if (AUTO_DECODE != 0) begin
      case (opcode)
        7'b0010011: fmt = (funct3 == 3'b001 || funct3 == 3'b101) ? 3'b101 : 3'b000;
        7'b0000011, 7'b1100111, 7'b1110011: fmt = 3'b000;
        7'b0100011: fmt = 3'b001;
        7'b1100011: fmt = 3'b010;
        7'b1101111: fmt = 3'b011;
        7'b0110111, 7'b0010111: fmt = 3'b100;
        default:    fmt = 3'b111;
      endcase
    end else begin
      fmt = bus.in_imm_src;
    end
  end

  // Every signed format has instr[31] in bit 31 and SHAMT has bit 31 clear,
  // so one sign extension of the 32-bit value covers all formats for XLEN=64.
  always_comb begin
    imm32 = 32'b0;
    case (fmt)
      3'b000: imm32 = {{20{instr[31]}}, instr[31:20]};
      3'b001: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      3'b010: imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      3'b011: imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      3'b100: imm32 = {instr[31:12], 12'b0};
      3'b101: imm32 = (XLEN == 64) ? {26'b0, instr[25:20]} : {27'b0, instr[24:20]};
      default: imm32 = 32'b0;
    endcase
  end

  assign imm     = XLEN'($signed(imm32));
  assign illegal = fmt[2] & fmt[1];

  assign full  = (count == CW'(FIFO_DEPTH));
  assign valid = (count != '0);
  assign push  = bus.in_valid && !full;
  assign pop   = valid && bus.out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {imm, fmt, illegal};
  end

  assign head            = mem[rd_ptr];
  assign bus.in_ready    = !full;
  assign bus.out_valid   = valid;
  assign bus.out_imm     = valid ? head[EW-1:4] : '0;
  assign bus.out_type    = valid ? head[3:1]    : 3'b0;
  assign bus.out_illegal = valid ? head[0]      : 1'b0;

`ifdef IMM_GEN_STATS_EN
  logic [15:0] acc_cnt;
  logic [15:0] ill_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_cnt <= '0;
      ill_cnt <= '0;
    end else begin
      if (push && acc_cnt != 16'hFFFF) acc_cnt <= acc_cnt + 16'd1;
      if (push && illegal && ill_cnt != 16'hFFFF) ill_cnt <= ill_cnt + 16'd1;
    end
  end

  assign stat_accepted = acc_cnt;
  assign stat_illegal  = ill_cnt;
`else
  assign stat_accepted = '0;
  assign stat_illegal  = '0;
`endif
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - scoreboard bench for imm_gen_pipe (XLEN 32 and 64 instances)
module tb_imm_gen_pipe;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        flush;
  logic [15:0] stat_acc, stat_ill, stat_acc64, stat_ill64;

  imm_gen_pipe_if #(.XLEN(32)) bus ();
  imm_gen_pipe_if #(.XLEN(64)) bus64 ();

  imm_gen_pipe #(.XLEN(32), .FIFO_DEPTH(2), .AUTO_DECODE(1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus),
    .stat_accepted(stat_acc), .stat_illegal(stat_ill)
  );

  imm_gen_pipe #(.XLEN(64), .FIFO_DEPTH(2), .AUTO_DECODE(1)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus64),
    .stat_accepted(stat_acc64), .stat_illegal(stat_ill64)
  );

  typedef struct packed {
    logic [63:0] imm;
    logic [2:0]  typ;
    logic        ill;
  } exp_t;

  exp_t        exp_q[$];
  int          total = 0;
  int          bad = 0;
  int          acc_n = 0;
  int          ill_n = 0;
  logic        stalled = 1'b0;
  logic [31:0] held_imm;
  logic [2:0]  held_typ;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [31:0] w, input logic [63:0] imm, input logic [2:0] t, input logic il);
    int n = 0;
    exp_t e;
    bus.in_valid = 1'b1;
    bus.in_instr = w;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got in_ready=0 want accept of %h", w);
    end else begin
      e.imm = imm; e.typ = t; e.ill = il;
      exp_q.push_back(e);
      acc_n++;
      if (il) ill_n++;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    #2;
    if (!rst_n || flush) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        chk("hold_imm", {32'b0, bus.out_imm}, {32'b0, held_imm});
        chk("hold_type", {61'b0, bus.out_type}, {61'b0, held_typ});
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_out: got imm %h with empty scoreboard", bus.out_imm);
        end else begin
          e = exp_q.pop_front();
          chk("out_imm", {32'b0, bus.out_imm}, e.imm);
          chk("out_type", {61'b0, bus.out_type}, {61'b0, e.typ});
          chk("out_illegal", {63'b0, bus.out_illegal}, {63'b0, e.ill});
        end
      end
      if (!bus.out_valid)
        chk("idle_zero", {28'b0, bus.out_imm, bus.out_type, bus.out_illegal}, 64'd0);
      stalled  = bus.out_valid && !bus.out_ready;
      held_imm = bus.out_imm;
      held_typ = bus.out_type;
    end
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0;
    bus.in_valid = 1'b0; bus.in_instr = '0; bus.in_imm_src = '0; bus.out_ready = 1'b0;
    bus64.in_valid = 1'b0; bus64.in_instr = '0; bus64.in_imm_src = '0; bus64.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", {63'b0, bus.out_valid}, 64'd0);
    chk("rst_in_ready", {63'b0, bus.in_ready}, 64'd1);
    chk("rst_fields", {28'b0, bus.out_imm, bus.out_type, bus.out_illegal}, 64'd0);
    chk("rst_stats", {32'b0, stat_acc, stat_ill}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    bus.out_ready = 1'b1;
    send(32'hFFF00093, 64'hFFFFFFFF, 3'b000, 1'b0);
    chk("latency_valid", {63'b0, bus.out_valid}, 64'd1);
    send(32'h00112623, 64'h0000000C, 3'b001, 1'b0);
    send(32'hFE000EE3, 64'hFFFFFFFC, 3'b010, 1'b0);
    send(32'hFF9FF06F, 64'hFFFFFFF8, 3'b011, 1'b0);
    send(32'h4030D093, 64'h00000003, 3'b101, 1'b0);
    send(32'h43F0D093, 64'h0000001F, 3'b101, 1'b0);
    send(32'h00402083, 64'h00000004, 3'b000, 1'b0);
    send(32'h800000B7, 64'h80000000, 3'b100, 1'b0);
    send(32'h0000007F, 64'h00000000, 3'b111, 1'b1);
    drain();
`ifdef IMM_GEN_STATS_EN
    chk("stat_accepted", {48'b0, stat_acc}, 64'(acc_n));
    chk("stat_illegal", {48'b0, stat_ill}, 64'(ill_n));
`else
    chk("stat_accepted_off", {48'b0, stat_acc}, 64'd0);
    chk("stat_illegal_off", {48'b0, stat_ill}, 64'd0);
`endif

    bus64.in_valid = 1'b1;
    bus64.in_instr = 32'h800000B7;
    @(negedge clk);
    bus64.in_instr = 32'h43F0D093;
    chk("x64_lui_valid", {63'b0, bus64.out_valid}, 64'd1);
    chk("x64_lui_imm", bus64.out_imm, 64'hFFFFFFFF80000000);
    chk("x64_lui_type", {61'b0, bus64.out_type}, 64'd4);
    @(negedge clk);
    bus64.in_valid = 1'b0;
    chk("x64_shamt_imm", bus64.out_imm, 64'd63);
    chk("x64_shamt_type", {61'b0, bus64.out_type}, 64'd5);
    @(negedge clk);

    bus.out_ready = 1'b0;
    send(32'h00112623, 64'h0000000C, 3'b001, 1'b0);
    send(32'hFE000EE3, 64'hFFFFFFFC, 3'b010, 1'b0);
    chk("full_in_ready", {63'b0, bus.in_ready}, 64'd0);
    fork
      send(32'hFF9FF06F, 64'hFFFFFFF8, 3'b011, 1'b0);
    join_none
    repeat (3) @(negedge clk);
    chk("held_in_ready", {63'b0, bus.in_ready}, 64'd0);
    chk("held_queue_len", 64'(exp_q.size()), 64'd2);
    bus.out_ready = 1'b1;
    drain();
    repeat (2) @(negedge clk);

    bus.out_ready = 1'b0;
    send(32'hFFF00093, 64'hFFFFFFFF, 3'b000, 1'b0);
    send(32'h00112623, 64'h0000000C, 3'b001, 1'b0);
    flush = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_instr = 32'h00402083;
    exp_q.delete();
    @(negedge clk);
    flush = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_out_valid", {63'b0, bus.out_valid}, 64'd0);
    chk("flush_in_ready", {63'b0, bus.in_ready}, 64'd1);
    bus.out_ready = 1'b1;
    send(32'h00402083, 64'h00000004, 3'b000, 1'b0);
    drain();

    bus.out_ready = 1'b0;
    send(32'hFFF00093, 64'hFFFFFFFF, 3'b000, 1'b0);
    send(32'hFE000EE3, 64'hFFFFFFFC, 3'b010, 1'b0);
    rst_n = 1'b0;
    exp_q.delete();
    acc_n = 0;
    ill_n = 0;
    @(negedge clk);
    chk("mid_rst_out_valid", {63'b0, bus.out_valid}, 64'd0);
    chk("mid_rst_in_ready", {63'b0, bus.in_ready}, 64'd1);
    chk("mid_rst_fields", {28'b0, bus.out_imm, bus.out_type, bus.out_illegal}, 64'd0);
    chk("mid_rst_stats", {32'b0, stat_acc, stat_ill}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b1;
    send(32'h0000007F, 64'h00000000, 3'b111, 1'b1);
    drain();
`ifdef IMM_GEN_STATS_EN
    chk("stat_after_rst", {32'b0, stat_acc, stat_ill}, {32'b0, 16'(acc_n), 16'(ill_n)});
`endif

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Parametrised, buffered immediate generator for the decode stage. Accepts 32-bit RISC-V instruction words over a valid/ready handshake. Extracts and sign-extends the immediate for the I, S, B, J, U and shift-amount formats to XLEN bits. Delivers results in order through a small FIFO, so fetch and execute can stall independently.

Parameters:
XLEN, 32, output immediate width; legal values 32 or 64
FIFO_DEPTH, 2, result buffer entries; power of two, >=2
AUTO_DECODE, 1, 1: format derived from opcode/funct3; 0: format taken from in_imm_src

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
flush  in  1  discard all buffered results
in_valid  in  1  instruction offered
in_ready  out  1  block can accept
in_instr  in  32  instruction word
in_imm_src  in  3  explicit format, used only when AUTO_DECODE=0
out_valid  out  1  result available at FIFO head
out_ready  in  1  consumer accepts head
out_imm  out  XLEN  sign-extended immediate
out_type  out  3  format code of head entry
out_illegal  out  1  head entry had no immediate format
stat_accepted  out  16  accepted-instruction count (see Optional Feature)
stat_illegal  out  16  illegal-format count (see Optional Feature)

Behaviour:
- Format codes: 000 I, 001 S, 010 B, 011 J, 100 U, 101 SHAMT; 110 and 111 are illegal.
- Illegal entries are stored with imm=0, out_illegal=1 and type equal to the offending code (110 or 111).
- AUTO_DECODE opcode map:
  - 0010011: SHAMT if funct3 is 001 or 101, otherwise I.
  - 0000011, 1100111, 1110011: I.
  - 0100011: S. 1100011: B. 1101111: J. 0110111 and 0010111: U.
  - Any other opcode: illegal, code 111.
- Extraction, from instr[31:0]:
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - U: {instr[31:12], 12'b0}.
  - All of the above are sign-extended from instr[31] to XLEN.
  - SHAMT: zero-extended instr[24:20] for XLEN=32, instr[25:20] for XLEN=64.
- Decode is combinational at the write port. The FIFO stores {imm, type, illegal}.
- Handshake:
  - Accept when in_valid && in_ready. in_ready = !full (registered count, no combinational path from out_ready).
  - Pop when out_valid && out_ready. out_valid = !empty.
- Latency: an entry accepted in cycle N gives out_valid in N+1 when the FIFO was empty. There is no same-cycle bypass.
- Full: in_ready=0. Upstream must hold in_instr stable while in_valid=1.
- Push and pop in the same cycle: both occur and occupancy is unchanged. This cannot happen while full, because in_ready=0.
- Pointers wrap modulo FIFO_DEPTH. Occupancy counter is clog2(FIFO_DEPTH)+1 bits.
- Output fields at the head are held stable while out_valid && !out_ready.
- flush: next cycle, pointers and count are 0 and out_valid=0. Any push or pop in the flush cycle is discarded.
- Reset (rst_n=0 at a clock edge):
  - out_valid=0, in_ready=1, out_imm=0, out_type=0, out_illegal=0, stat counters=0.
  - Mid-operation reset drops all entries.
  - Reset has priority over flush.
- When out_valid=0, out_imm, out_type and out_illegal are driven 0.

Optional Feature:
IMM_GEN_STATS_EN
- Defined: stat_accepted increments on each accepted instruction. stat_illegal increments on each accepted illegal one. Both saturate at 0xFFFF, are cleared by reset only (not by flush), and are registered.
- Undefined: both ports are tied to 0 and no counter flops exist.

Test Plan:
- AUTO_DECODE=1, XLEN=32, out_ready=1, push 0xFFF00093 (addi x1,x0,-1) -> next cycle out_valid=1, out_imm=0xFFFFFFFF, out_type=000.
- Push 0x00112623 (sw), then 0xFE000EE3 (beq -4), then 0xFF9FF06F (jal -8) -> in order: 0x0000000C/001, 0xFFFFFFFC/010, 0xFFFFFFF8/011.
- Push 0x4030D093 (srai x1,x1,3) -> out_imm=0x00000003, type 101. With XLEN=64, push 0x800000B7 (lui 0x80000) -> out_imm=0xFFFFFFFF80000000, type 100.
- FIFO_DEPTH=2, out_ready=0, push three words -> in_ready=0 after the 2nd accept and the 3rd is held. Raise out_ready -> all three emerge in order, one per cycle, with no loss or duplication.
- Push 0x0000007F -> out_illegal=1, out_imm=0, type 111. With IMM_GEN_STATS_EN, after 5 accepts including 1 illegal -> stat_accepted=5, stat_illegal=1.
- With 2 entries buffered, assert flush together with in_valid -> next cycle out_valid=0 and count=0. Separately, drop rst_n mid-stream -> all outputs 0 and in_ready=1 next cycle.
